sprite_pixel_pipe: RTL and testbench

//  Pipelined sprite-pixel fetch unit between the game logic and the VGA driver.
//  Per request, it looks up the sprite descriptor (base, height, width) and forms the ROM address.
//  It then waits out the ROM read latency and applies colour-key and background substitution, an AND mask and channel order.

---
 rtl/sprite_pixel_pipe.sv | 145 ++++++++++++++
 tb/tb_sprite_pixel_pipe.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_pixel_pipe.sv
// Sprite pixel fetch pipeline: descriptor lookup and ROM address (stage A), a delay line
// matched to the image ROM latency, then key/background substitution, mask and swap (stage B).
module sprite_pixel_pipe #(
  parameter int              TYPE_W      = 6,
  parameter int              DIM_W       = 11,
  parameter int              ADDR_W      = 19,
  parameter int              PIX_W       = 12,
  parameter int              ROM_LATENCY = 1,
  parameter logic [PIX_W-1:0] KEY_COLOR  = 12'hF0F,
  parameter logic [PIX_W-1:0] BG_COLOR   = 12'h9CD,
  parameter bit              SWAP_RB     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [TYPE_W-1:0] in_type,
  input  logic [DIM_W-1:0]  in_h,
  input  logic [DIM_W-1:0]  in_w,
  input  logic [PIX_W-1:0]  in_mask,
  output logic [TYPE_W-1:0] obj_id,
  input  logic [ADDR_W-1:0] obj_base,
  input  logic [DIM_W-1:0]  obj_height,
  input  logic [DIM_W-1:0]  obj_width,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [PIX_W-1:0]  rom_data,
  output logic              out_valid,
  output logic [PIX_W-1:0]  out_pixel,
  output logic              out_transparent,
  output logic [31:0]       pix_count
);

  localparam int CH_W   = PIX_W / 3;
  localparam int PROD_W = 2 * DIM_W;
  localparam int SUM_W  = (ADDR_W > PROD_W) ? ADDR_W : PROD_W;

  logic [PROD_W-1:0] w_prod;
  logic [ADDR_W-1:0] w_addr;
  logic              w_oor;

  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_a_valid;
  logic              r_a_oor;
  logic [PIX_W-1:0]  r_a_mask;

  logic [ROM_LATENCY-1:0]            r_dl_valid;
  logic [ROM_LATENCY-1:0]            r_dl_oor;
  logic [ROM_LATENCY-1:0][PIX_W-1:0] r_dl_mask;

  logic             w_tail_valid;
  logic             w_tail_oor;
  logic [PIX_W-1:0] w_tail_mask;
  logic             w_transp;
  logic [PIX_W-1:0] w_masked;
  logic [PIX_W-1:0] w_pix_out;

  logic             r_out_valid;
  logic [PIX_W-1:0] r_out_pixel;
  logic             r_out_transp;
  logic [31:0]      r_pix_count;

  // Stage A: descriptor returns combinationally for the id we present this cycle.
  assign obj_id = in_type;
  assign w_prod = PROD_W'(in_h) * PROD_W'(obj_width);
  assign w_addr = ADDR_W'(SUM_W'(obj_base) + SUM_W'(w_prod) + SUM_W'(in_w));
  assign w_oor  = (in_h >= obj_height) || (in_w >= obj_width);

  // NOTE: sequential state is always updated with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rom_addr <= '0;
      r_a_valid  <= 1'b0;
    end else begin
      r_a_valid <= in_valid;
      if (in_valid) r_rom_addr <= w_addr;
    end
  end

  // NOTE: payload registers carry no reset; only the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      r_a_oor  <= w_oor;
      r_a_mask <= in_mask;
    end
  end

  // Delay line: the tail lines up with rom_data for the same request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dl_valid <= '0;
    end else begin
      r_dl_valid[0] <= r_a_valid;
      for (int i = 1; i < ROM_LATENCY; i++) r_dl_valid[i] <= r_dl_valid[i-1];
    end
  end

  always_ff @(posedge clk) begin
    r_dl_oor[0]  <= r_a_oor;
    r_dl_mask[0] <= r_a_mask;
    for (int i = 1; i < ROM_LATENCY; i++) begin
      r_dl_oor[i]  <= r_dl_oor[i-1];
      r_dl_mask[i] <= r_dl_mask[i-1];
    end
  end

  assign w_tail_valid = r_dl_valid[ROM_LATENCY-1];
  assign w_tail_oor   = r_dl_oor[ROM_LATENCY-1];
  assign w_tail_mask  = r_dl_mask[ROM_LATENCY-1];

  // Key compare on raw ROM data; mask is applied before the channel swap.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    w_transp  = 1'b0;
    w_masked  = '0;
    w_pix_out = '0;
    w_transp  = w_tail_oor || (rom_data == KEY_COLOR);
    w_masked  = (w_transp ? BG_COLOR : rom_data) & w_tail_mask;
    if (SWAP_RB)
      w_pix_out = {w_masked[CH_W-1:0], w_masked[2*CH_W-1:CH_W], w_masked[PIX_W-1:2*CH_W]};
    else
      w_pix_out = w_masked;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_pixel  <= '0;
      r_out_transp <= 1'b0;
      r_pix_count  <= '0;
    end else begin
      r_out_valid <= w_tail_valid;
      if (w_tail_valid) begin
        r_out_pixel  <= w_pix_out;
        r_out_transp <= w_transp;
        r_pix_count  <= r_pix_count + 32'd1;
      end
    end
  end

  assign rom_addr        = r_rom_addr;
  assign out_valid       = r_out_valid;
  assign out_pixel       = r_out_pixel;
  assign out_transparent = r_out_transp;
  assign pix_count       = r_pix_count;

endmodule

// File: tb/tb_sprite_pixel_pipe.sv
// Self-checking bench for sprite_pixel_pipe: two instances (ROM latency 1 and 3) share stimulus
// and are compared against a descriptor/ROM reference model computed with plain arithmetic.
module tb_sprite_pixel_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [5:0]  in_type;
  logic [10:0] in_h, in_w;
  logic [11:0] in_mask;

  logic [5:0]  obj_id_1, obj_id_3;
  logic [18:0] obj_base_1, obj_base_3;
  logic [10:0] obj_height_1, obj_height_3, obj_width_1, obj_width_3;
  logic [18:0] rom_addr_1, rom_addr_3;
  logic [11:0] rom_data_1, rom_data_3;
  logic        out_valid_1, out_valid_3, out_transp_1, out_transp_3;
  logic [11:0] out_pixel_1, out_pixel_3;
  logic [31:0] pix_count_1, pix_count_3;

  logic [18:0] d_base   [64];
  logic [10:0] d_height [64];
  logic [10:0] d_width  [64];
  logic [11:0] rom_ovr  [int];

  int n_tests = 0;
  int n_fail  = 0;
  int sent    = 0;

  always #5 clk = ~clk;

  assign obj_base_1   = d_base[obj_id_1];
  assign obj_height_1 = d_height[obj_id_1];
  assign obj_width_1  = d_width[obj_id_1];
  assign obj_base_3   = d_base[obj_id_3];
  assign obj_height_3 = d_height[obj_id_3];
  assign obj_width_3  = d_width[obj_id_3];

  sprite_pixel_pipe #(.ROM_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_type(in_type), .in_h(in_h), .in_w(in_w),
    .in_mask(in_mask), .obj_id(obj_id_1), .obj_base(obj_base_1), .obj_height(obj_height_1),
    .obj_width(obj_width_1), .rom_addr(rom_addr_1), .rom_data(rom_data_1),
    .out_valid(out_valid_1), .out_pixel(out_pixel_1), .out_transparent(out_transp_1),
    .pix_count(pix_count_1)
  );

  sprite_pixel_pipe #(.ROM_LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_type(in_type), .in_h(in_h), .in_w(in_w),
    .in_mask(in_mask), .obj_id(obj_id_3), .obj_base(obj_base_3), .obj_height(obj_height_3),
    .obj_width(obj_width_3), .rom_addr(rom_addr_3), .rom_data(rom_data_3),
    .out_valid(out_valid_3), .out_pixel(out_pixel_3), .out_transparent(out_transp_3),
    .pix_count(pix_count_3)
  );

  // Image ROM contents: directed overrides, otherwise a fixed function of the address.
  function automatic logic [11:0] rom_fn(input int a);
    if (rom_ovr.exists(a)) return rom_ovr[a];
    if (a % 5 == 0) return 12'hF0F;
    return 12'(a * 37 + (a >> 7) + 11);
  endfunction

  // ROM models with read latency 1 and 3.
  logic [11:0] rp1;
  logic [11:0] rp3 [3];
  always @(posedge clk) begin
    rp1    <= rom_fn(int'(rom_addr_1));
    rp3[0] <= rom_fn(int'(rom_addr_3));
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end
  assign rom_data_1 = rp1;
  assign rom_data_3 = rp3[2];

  function automatic int ref_addr(input int t, input int h, input int w);
    longint a;
    a = longint'(d_base[t]) + longint'(h) * longint'(d_width[t]) + longint'(w);
    return int'(a % 64'd524288);
  endfunction

  // Returns {transparent, pixel} for one request.
  function automatic logic [12:0] ref_pix(input int t, input int h, input int w, input logic [11:0] m);
    bit          tr;
    logic [11:0] raw, p;
    int          pi, ps;
    raw = rom_fn(ref_addr(t, h, w));
    tr  = (h >= int'(d_height[t])) || (w >= int'(d_width[t])) || (raw == 12'hF0F);
    p   = (tr ? 12'h9CD : raw) & m;
    pi  = int'(p);
    ps  = ((pi % 16) * 256) + (((pi / 16) % 16) * 16) + (pi / 256);
    return {tr, 12'(ps)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int t, input int h, input int w, input logic [11:0] m);
    in_valid = v;
    in_type  = 6'(t);
    in_h     = 11'(h);
    in_w     = 11'(w);
    in_mask  = m;
    if (v) sent++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, 0, 1, 1, 12'hFFF);
    step();
    step();
    rst = 1'b0;
    drive(1'b0, 0, 0, 0, 12'h000);
    sent = 0;
  endtask

  // Drives one request, then bubbles until the latency-1 instance presents it.
  task automatic issue_single(input int t, input int h, input int w, input logic [11:0] m);
    drive(1'b1, t, h, w, m);
    step();
    drive(1'b0, 0, 0, 0, 12'h000);
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 0, 3, 4, 12'hFFF);
    for (int i = 0; i < 3; i++) step();
    n_tests++;
    if ({rom_addr_1, out_valid_1, out_pixel_1, out_transp_1, pix_count_1} !== '0) begin
      n_fail++;
      $display("FAIL reset_l1: got addr=%h v=%b pix=%h t=%b cnt=%0d, expected all zero",
               rom_addr_1, out_valid_1, out_pixel_1, out_transp_1, pix_count_1);
    end
    n_tests++;
    if ({rom_addr_3, out_valid_3, out_pixel_3, out_transp_3, pix_count_3} !== '0) begin
      n_fail++;
      $display("FAIL reset_l3: got addr=%h v=%b pix=%h t=%b cnt=%0d, expected all zero",
               rom_addr_3, out_valid_3, out_pixel_3, out_transp_3, pix_count_3);
    end
    rst = 1'b0;
    drive(1'b0, 0, 0, 0, 12'h000);
    sent = 0;
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if ({out_valid_1, out_valid_3, pix_count_1, pix_count_3} !== '0) begin
        n_fail++;
        $display("FAIL reset_ignore_cyc%0d: got v1=%b v3=%b c1=%0d c3=%0d, expected 0",
                 i, out_valid_1, out_valid_3, pix_count_1, pix_count_3);
      end
      step();
    end
  endtask

  task automatic test_basic_fetch();
    d_base[1] = 19'h00100; d_height[1] = 11'd32; d_width[1] = 11'd16;
    rom_ovr[32'h123] = 12'h0A5;
    drive(1'b1, 1, 2, 3, 12'hFFF);
    #1;
    n_tests++;
    if (obj_id_1 !== 6'd1) begin
      n_fail++; $display("FAIL obj_id: got %0d, expected 1", obj_id_1);
    end
    step();
    drive(1'b0, 0, 0, 0, 12'h000);
    n_tests++;
    if ({rom_addr_1, rom_addr_3} !== {19'h00123, 19'h00123}) begin
      n_fail++; $display("FAIL rom_addr: got %h/%h, expected 00123", rom_addr_1, rom_addr_3);
    end
    step();
    n_tests++;
    if ({out_valid_1, rom_addr_1} !== {1'b0, 19'h00123}) begin
      n_fail++; $display("FAIL early_or_hold: got v=%b addr=%h, expected v=0 addr=00123", out_valid_1, rom_addr_1);
    end
    step();
    n_tests++;
    if ({out_valid_1, out_transp_1, out_pixel_1, pix_count_1} !== {1'b1, 1'b0, 12'h5A0, 32'(sent)}) begin
      n_fail++; $display("FAIL basic_l1: got v=%b t=%b pix=%h cnt=%0d, expected 1 0 5a0 %0d",
                         out_valid_1, out_transp_1, out_pixel_1, pix_count_1, sent);
    end
    step();
    n_tests++;
    if ({out_valid_1, out_pixel_1} !== {1'b0, 12'h5A0}) begin
      n_fail++; $display("FAIL bubble_hold: got v=%b pix=%h, expected 0 5a0", out_valid_1, out_pixel_1);
    end
    step();
    n_tests++;
    if ({out_valid_3, out_transp_3, out_pixel_3, pix_count_3} !== {1'b1, 1'b0, 12'h5A0, 32'(sent)}) begin
      n_fail++; $display("FAIL basic_l3: got v=%b t=%b pix=%h cnt=%0d, expected 1 0 5a0 %0d",
                         out_valid_3, out_transp_3, out_pixel_3, pix_count_3, sent);
    end
  endtask

  task automatic test_colour_key();
    int          hs [3] = '{1, 2, 3};
    logic [11:0] ms [3] = '{12'hFFF, 12'h0F0, 12'hF0F};
    logic [11:0] rv [3] = '{12'hF0F, 12'hF0F, 12'hFFF};
    logic [12:0] ex [3] = '{{1'b1, 12'hDC9}, {1'b1, 12'h0C0}, {1'b0, 12'hF0F}};
    d_base[2] = 19'h00200; d_height[2] = 11'd8; d_width[2] = 11'd8;
    for (int i = 0; i < 3; i++) begin
      rom_ovr[32'h200 + hs[i] * 9] = rv[i];
      issue_single(2, hs[i], hs[i], ms[i]);
      n_tests++;
      if ({out_valid_1, out_transp_1, out_pixel_1} !== {1'b1, ex[i]}) begin
        n_fail++; $display("FAIL colour_key_%0d: got v=%b t=%b pix=%h, expected 1 %b %h",
                           i, out_valid_1, out_transp_1, out_pixel_1, ex[i][12], ex[i][11:0]);
      end
    end
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_out_of_range();
    int          ts [4] = '{3, 3, 3, 4};
    int          hs [4] = '{20, 0, 19, 0};
    int          ws [4] = '{0, 10, 9, 0};
    logic [12:0] ex [4] = '{{1'b1, 12'hDC9}, {1'b1, 12'hDC9}, {1'b0, 12'h5A0}, {1'b1, 12'hDC9}};
    d_base[3] = 19'h00300; d_height[3] = 11'd20; d_width[3] = 11'd10;
    d_base[4] = 19'h00400; d_height[4] = 11'd5;  d_width[4] = 11'd0;
    rom_ovr[32'h3C8] = 12'h0A5;
    rom_ovr[32'h30A] = 12'h0A5;
    rom_ovr[32'h3C7] = 12'h0A5;
    rom_ovr[32'h400] = 12'h0A5;
    for (int i = 0; i < 4; i++) begin
      issue_single(ts[i], hs[i], ws[i], 12'hFFF);
      n_tests++;
      if ({out_valid_1, out_transp_1, out_pixel_1} !== {1'b1, ex[i]}) begin
        n_fail++; $display("FAIL range_%0d: got v=%b t=%b pix=%h, expected 1 %b %h",
                           i, out_valid_1, out_transp_1, out_pixel_1, ex[i][12], ex[i][11:0]);
      end
    end
    for (int i = 0; i < 3; i++) step();
    n_tests++;
    if ({pix_count_1, pix_count_3} !== {32'(sent), 32'(sent)}) begin
      n_fail++; $display("FAIL count_after_directed: got %0d/%0d, expected %0d", pix_count_1, pix_count_3, sent);
    end
  endtask

  task automatic test_back_to_back();
    bit          pat [10] = '{1, 1, 1, 0, 1, 1, 1, 0, 1, 1};
    logic [12:0] e   [10];
    int          h, w;
    logic [11:0] m;
    bit          ev;
    d_base[6] = 19'h12345; d_height[6] = 11'd30; d_width[6] = 11'd30;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (i < 10) begin
        h = $urandom_range(0, 34);
        w = $urandom_range(0, 34);
        m = ($urandom_range(0, 1) == 0) ? 12'hFFF : 12'($urandom);
        e[i] = ref_pix(6, h, w, m);
        drive(pat[i], 6, h, w, m);
      end else begin
        drive(1'b0, 0, 0, 0, 12'h000);
      end
      ev = (i >= 5 && i < 15) ? pat[i-5] : 1'b0;
      n_tests++;
      if (out_valid_3 !== ev || (ev && {out_transp_3, out_pixel_3} !== e[i-5])) begin
        n_fail++; $display("FAIL b2b_l3_cyc%0d: got v=%b t=%b pix=%h, expected v=%b %h",
                           i, out_valid_3, out_transp_3, out_pixel_3, ev, (i >= 5 && i < 15) ? e[i-5] : 13'h0);
      end
      ev = (i >= 3 && i < 13) ? pat[i-3] : 1'b0;
      n_tests++;
      if (out_valid_1 !== ev || (ev && {out_transp_1, out_pixel_1} !== e[i-3])) begin
        n_fail++; $display("FAIL b2b_l1_cyc%0d: got v=%b t=%b pix=%h, expected v=%b %h",
                           i, out_valid_1, out_transp_1, out_pixel_1, ev, (i >= 3 && i < 13) ? e[i-3] : 13'h0);
      end
      step();
    end
    n_tests++;
    if ({pix_count_1, pix_count_3} !== {32'd8, 32'd8}) begin
      n_fail++; $display("FAIL b2b_count: got %0d/%0d, expected 8", pix_count_1, pix_count_3);
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6, i, i, 12'hFFF);
      step();
    end
    drive(1'b0, 0, 0, 0, 12'h000);
    rst = 1'b1;
    step();
    rst  = 1'b0;
    sent = 0;
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if ({out_valid_1, out_valid_3, pix_count_1, pix_count_3} !== '0) begin
        n_fail++; $display("FAIL midstream_cyc%0d: got v1=%b v3=%b c1=%0d c3=%0d, expected 0",
                           i, out_valid_1, out_valid_3, pix_count_1, pix_count_3);
      end
      step();
    end
  endtask

  task automatic test_addr_wrap();
    d_base[5] = 19'h7FFFC; d_height[5] = 11'd4; d_width[5] = 11'd8;
    d_base[7] = 19'h00000; d_height[7] = 11'd2047; d_width[7] = 11'd2047;
    rom_ovr[2] = 12'h123;
    drive(1'b1, 5, 0, 6, 12'h0F0);
    step();
    drive(1'b1, 7, 2046, 2046, 12'hFFF);
    n_tests++;
    if (rom_addr_1 !== 19'h00002) begin
      n_fail++; $display("FAIL wrap_addr: got %h, expected 00002", rom_addr_1);
    end
    step();
    drive(1'b0, 0, 0, 0, 12'h000);
    n_tests++;
    if (rom_addr_1 !== 19'(ref_addr(7, 2046, 2046))) begin
      n_fail++; $display("FAIL wide_product_addr: got %h, expected %h", rom_addr_1, 19'(ref_addr(7, 2046, 2046)));
    end
    step();
    n_tests++;
    if ({out_valid_1, out_transp_1, out_pixel_1} !== {1'b1, 1'b0, 12'h020}) begin
      n_fail++; $display("FAIL wrap_pixel: got v=%b t=%b pix=%h, expected 1 0 020", out_valid_1, out_transp_1, out_pixel_1);
    end
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_random();
    localparam int N = 400;
    bit          hv [N+8];
    logic [12:0] he [N+8];
    logic [12:0] hold1, hold3;
    int          cnt1, cnt3, t, h, w;
    logic [11:0] m;
    bit          v, ev1, ev3;
    for (int i = 8; i < 64; i++) begin
      d_base[i]   = 19'($urandom);
      d_height[i] = 11'($urandom_range(0, 40));
      d_width[i]  = 11'($urandom_range(0, 40));
    end
    do_reset();
    hold1 = '0; hold3 = '0; cnt1 = 0; cnt3 = 0;
    for (int i = 0; i < N + 8; i++) begin
      v = (i < N) && ($urandom_range(0, 9) < 8);
      t = $urandom_range(8, 63);
      h = $urandom_range(0, 44);
      w = $urandom_range(0, 44);
      m = ($urandom_range(0, 2) == 0) ? 12'($urandom) : 12'hFFF;
      hv[i] = v;
      he[i] = ref_pix(t, h, w, m);
      drive(v, t, h, w, m);
      #1;
      n_tests++;
      if (obj_id_1 !== 6'(t)) begin
        n_fail++; $display("FAIL rnd_obj_id_cyc%0d: got %0d, expected %0d", i, obj_id_1, t);
      end
      ev1 = (i >= 3) && hv[i-3];
      ev3 = (i >= 5) && hv[i-5];
      if (ev1) begin hold1 = he[i-3]; cnt1++; end
      if (ev3) begin hold3 = he[i-5]; cnt3++; end
      n_tests++;
      if ({out_valid_1, out_transp_1, out_pixel_1, pix_count_1} !== {ev1, hold1, 32'(cnt1)}) begin
        n_fail++; $display("FAIL rnd_l1_cyc%0d: got v=%b t=%b pix=%h cnt=%0d, expected v=%b %h cnt=%0d",
                           i, out_valid_1, out_transp_1, out_pixel_1, pix_count_1, ev1, hold1, cnt1);
      end
      n_tests++;
      if ({out_valid_3, out_transp_3, out_pixel_3, pix_count_3} !== {ev3, hold3, 32'(cnt3)}) begin
        n_fail++; $display("FAIL rnd_l3_cyc%0d: got v=%b t=%b pix=%h cnt=%0d, expected v=%b %h cnt=%0d",
                           i, out_valid_3, out_transp_3, out_pixel_3, pix_count_3, ev3, hold3, cnt3);
      end
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      d_base[i] = '0; d_height[i] = '0; d_width[i] = '0;
    end
    rst = 1'b1;
    drive(1'b0, 0, 0, 0, 12'h000);
    test_reset();
    test_basic_fetch();
    test_colour_key();
    test_out_of_range();
    test_back_to_back();
    test_reset_midstream();
    test_addr_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
